apb_master_ctrl: RTL and testbench

APB initiator that converts single-beat commands from an internal requester (CPU stub, DMA or test sequencer) into APB SETUP/ACCESS transfers toward the UART peripheral and other APB responders on the `pclk` domain. It sequences `pselx`/`penable`, honours responder wait states via `pready`, reports `pslverr`, and aborts stalled transfers with a programmable timeout. One transfer is in flight at a time; a response is returned for every accepted command.

---
 rtl/apb_master_ctrl.sv | 137 +++++++++++++
 tb/tb_apb_master_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// APB initiator: turns single-beat requester commands into SETUP/ACCESS transfers,
// honours pready wait states, reports pslverr and aborts stalled ACCESS phases on timeout.
module apb_master_ctrl #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic       pclk,
  input  logic       prstn,
  // Command channel: a command transfers on a rising pclk edge where cmd_valid and
  // cmd_ready are both high; the response channel has no ready and is a one-cycle strobe.
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       rsp_timeout,
  output logic       pselx,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic        TO_EN   = (TIMEOUT != 0);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] wait_cnt_q;
  logic        cmd_fire;
  logic        xfer_done;
  logic        xfer_abort;

  // Completion takes priority over a timeout firing in the same cycle.
  always_comb begin
    cmd_fire   = 1'b0;
    xfer_done  = 1'b0;
    xfer_abort = 1'b0;
    if (state_q == S_IDLE) begin
      cmd_fire = cmd_valid;
    end
    if (state_q == S_ACCESS) begin
      xfer_done  = pready;
      xfer_abort = !pready && TO_EN && (wait_cnt_q == TO_LAST);
    end
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cmd_fire) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (xfer_done || xfer_abort) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Bus strobes decode straight from the state register so an async reset drops them at once.
  always_comb begin
    cmd_ready = 1'b0;
    pselx     = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    state_dbg = state_q;
    case (state_q)
      S_IDLE:   cmd_ready = 1'b1;
      S_SETUP:  pselx     = 1'b1;
      S_ACCESS: begin
        pselx   = 1'b1;
        penable = 1'b1;
      end
      S_RESP:   rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      wait_cnt_q <= 16'd0;
    end else if (state_q != S_ACCESS) begin
      wait_cnt_q <= 16'd0;
    end else if (!pready) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      pwrite <= 1'b0;
      paddr  <= 8'h00;
      pwdata <= 8'h00;
    end else if (cmd_fire) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_write ? cmd_wdata : 8'h00;
    end
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      rsp_rdata   <= 8'h00;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (xfer_done) begin
      rsp_rdata   <= pwrite ? 8'h00 : prdata;
      rsp_err     <= pslverr;
      rsp_timeout <= 1'b0;
    end else if (xfer_abort) begin
      rsp_rdata   <= 8'h00;
      rsp_err     <= 1'b1;
      rsp_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: drives commands and a scripted APB responder,
// samples outputs on the falling edge and checks against hand-computed values.
module tb_apb_master_ctrl;

  logic       pclk = 1'b0;
  logic       prstn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic       pselx;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;

  localparam logic [30:0] RESET_VEC = {1'b1, 6'b0, 24'h000000};

  apb_master_ctrl #(.TIMEOUT(16)) dut (
    .pclk        (pclk),
    .prstn       (prstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .pselx       (pselx),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .state_dbg   (state_dbg)
  );

  always #5 pclk = ~pclk;

  // Called on a falling edge; returns on the falling edge right after the handshake.
  task automatic drive_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      @(negedge pclk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    cmd_addr  = 8'hEE;
    cmd_wdata = 8'hEE;
  endtask

  // Scripted responder: pready rises on ACCESS cycle number ready_at (0 = never).
  // Returns on the falling edge where rsp_valid is seen, or after a bounded wait.
  task automatic run_access(input int ready_at, input logic [7:0] rd, input logic err,
                            output int acc, output bit stable, output bit got_rsp);
    logic [7:0] a0;
    logic [7:0] d0;
    logic       w0;
    a0 = paddr;
    d0 = pwdata;
    w0 = pwrite;
    acc = 0;
    stable = 1'b1;
    got_rsp = 1'b0;
    pready = 1'b0;
    pslverr = 1'b1;
    prdata = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      if (rsp_valid) begin
        got_rsp = 1'b1;
        break;
      end
      if (pselx && penable) begin
        acc++;
        if (paddr !== a0 || pwdata !== d0 || pwrite !== w0) stable = 1'b0;
        if (ready_at != 0 && acc == ready_at) begin
          pready = 1'b1;
          pslverr = err;
          prdata = rd;
        end else begin
          pready = 1'b0;
          pslverr = 1'b1;
          prdata = 8'hFF;
        end
      end
    end
    pready = 1'b0;
    pslverr = 1'b0;
    prdata = 8'h00;
  endtask

  task automatic test_reset();
    prstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = 8'h00;
    cmd_wdata = 8'h00;
    prdata = 8'h00;
    pready = 1'b0;
    pslverr = 1'b0;
    repeat (2) @(negedge pclk);
    prstn = 1'b1;
    @(negedge pclk);
    checks++;
    if ({cmd_ready, pselx, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, paddr, pwdata, rsp_rdata} !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_outputs: got %h required %h",
               {cmd_ready, pselx, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, paddr, pwdata, rsp_rdata}, RESET_VEC);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d required 0", state_dbg);
    end
  endtask

  task automatic test_write();
    pready = 1'b1;
    pslverr = 1'b0;
    prdata = 8'h99;
    drive_cmd(1'b1, 8'hB0, 8'h8B);
    checks++;
    if ({pselx, penable, cmd_ready, state_dbg} !== 5'b100_01) begin
      errors++;
      $display("FAIL wr_setup: got %b required 10001", {pselx, penable, cmd_ready, state_dbg});
    end
    @(negedge pclk);
    checks++;
    if ({pselx, penable, pwrite, paddr, pwdata, state_dbg} !== {3'b111, 8'hB0, 8'h8B, 2'd2}) begin
      errors++;
      $display("FAIL wr_access: got %h required %h",
               {pselx, penable, pwrite, paddr, pwdata, state_dbg}, {3'b111, 8'hB0, 8'h8B, 2'd2});
    end
    @(negedge pclk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, pselx, penable} !== {3'b100, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL wr_resp: got %h required %h",
               {rsp_valid, rsp_err, rsp_timeout, rsp_rdata, pselx, penable}, {3'b100, 8'h00, 2'b00});
    end
    pready = 1'b0;
    @(negedge pclk);
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL wr_idle: got %b required 10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_wait_read();
    int acc;
    bit stable;
    bit got;
    drive_cmd(1'b0, 8'hB4, 8'h77);
    run_access(4, 8'hA1, 1'b0, acc, stable, got);
    checks++;
    if (got !== 1'b1 || acc != 4) begin
      errors++;
      $display("FAIL rd_wait_len: rsp=%0b access_cycles=%0d required rsp=1 access_cycles=4", got, acc);
    end
    checks++;
    if (stable !== 1'b1 || paddr !== 8'hB4 || pwdata !== 8'h00) begin
      errors++;
      $display("FAIL rd_wait_bus: stable=%0b paddr=%h pwdata=%h required 1 b4 00", stable, paddr, pwdata);
    end
    checks++;
    if ({rsp_err, rsp_timeout, rsp_rdata} !== {2'b00, 8'hA1}) begin
      errors++;
      $display("FAIL rd_wait_rsp: got %h required %h", {rsp_err, rsp_timeout, rsp_rdata}, {2'b00, 8'hA1});
    end
    @(negedge pclk);
  endtask

  task automatic test_slverr();
    int acc;
    bit stable;
    bit got;
    drive_cmd(1'b0, 8'hB8, 8'h00);
    run_access(1, 8'h55, 1'b1, acc, stable, got);
    checks++;
    if (got !== 1'b1 || acc != 1) begin
      errors++;
      $display("FAIL slverr_len: rsp=%0b access_cycles=%0d required rsp=1 access_cycles=1", got, acc);
    end
    checks++;
    if ({rsp_err, rsp_timeout, rsp_rdata} !== {2'b10, 8'h55}) begin
      errors++;
      $display("FAIL slverr_rsp: got %h required %h", {rsp_err, rsp_timeout, rsp_rdata}, {2'b10, 8'h55});
    end
    @(negedge pclk);
  endtask

  task automatic test_timeout();
    int acc;
    bit stable;
    bit got;
    drive_cmd(1'b0, 8'hBC, 8'h00);
    run_access(0, 8'h00, 1'b0, acc, stable, got);
    checks++;
    if (got !== 1'b1 || acc != 16) begin
      errors++;
      $display("FAIL timeout_len: rsp=%0b access_cycles=%0d required rsp=1 access_cycles=16", got, acc);
    end
    checks++;
    if ({rsp_err, rsp_timeout, rsp_rdata} !== {2'b11, 8'h00}) begin
      errors++;
      $display("FAIL timeout_rsp: got %h required %h", {rsp_err, rsp_timeout, rsp_rdata}, {2'b11, 8'h00});
    end
    @(negedge pclk);
    drive_cmd(1'b0, 8'hBC, 8'h00);
    run_access(16, 8'h3C, 1'b0, acc, stable, got);
    checks++;
    if (got !== 1'b1 || acc != 16) begin
      errors++;
      $display("FAIL late_ready_len: rsp=%0b access_cycles=%0d required rsp=1 access_cycles=16", got, acc);
    end
    checks++;
    if ({rsp_err, rsp_timeout, rsp_rdata} !== {2'b00, 8'h3C}) begin
      errors++;
      $display("FAIL late_ready_rsp: got %h required %h", {rsp_err, rsp_timeout, rsp_rdata}, {2'b00, 8'h3C});
    end
    @(negedge pclk);
  endtask

  task automatic test_back_to_back();
    int         hs_cyc[2];
    logic [7:0] rsp_rd[2];
    int         n_hs = 0;
    int         n_rsp = 0;
    logic       pending;
    hs_cyc[0] = 0;
    hs_cyc[1] = 0;
    rsp_rd[0] = 8'hXX;
    rsp_rd[1] = 8'hXX;
    pready = 1'b1;
    pslverr = 1'b0;
    prdata = 8'h5A;
    cmd_write = 1'b1;
    cmd_addr = 8'hB0;
    cmd_wdata = 8'h11;
    cmd_valid = 1'b1;
    pending = cmd_ready;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge pclk);
      if (rsp_valid) begin
        if (n_rsp < 2) rsp_rd[n_rsp] = rsp_rdata;
        n_rsp++;
      end
      if (pending) begin
        if (n_hs < 2) hs_cyc[n_hs] = cyc;
        n_hs++;
        if (n_hs == 1) begin
          cmd_write = 1'b0;
          cmd_addr = 8'hB4;
          cmd_wdata = 8'h22;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      pending = cmd_valid && cmd_ready;
    end
    pready = 1'b0;
    prdata = 8'h00;
    checks++;
    if (n_hs != 2 || hs_cyc[1] - hs_cyc[0] != 4) begin
      errors++;
      $display("FAIL b2b_spacing: handshakes=%0d gap=%0d required 2 and 4", n_hs, hs_cyc[1] - hs_cyc[0]);
    end
    checks++;
    if (n_rsp != 2) begin
      errors++;
      $display("FAIL b2b_rsp_count: got %0d required 2", n_rsp);
    end
    checks++;
    if (rsp_rd[0] !== 8'h00 || rsp_rd[1] !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_rsp_order: got %h,%h required 00,5a", rsp_rd[0], rsp_rd[1]);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_rsp = 1'b0;
    pready = 1'b0;
    drive_cmd(1'b0, 8'hC4, 8'h00);
    repeat (2) @(negedge pclk);
    checks++;
    if ({pselx, penable} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_access: got %b required 11", {pselx, penable});
    end
    #2;
    prstn = 1'b0;
    #1;
    checks++;
    if ({pselx, penable} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_async_drop: got %b required 00", {pselx, penable});
    end
    repeat (3) begin
      @(negedge pclk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    prstn = 1'b1;
    repeat (4) begin
      @(negedge pclk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    checks++;
    if (saw_rsp !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_rsp: got rsp_valid seen=%0b required 0", saw_rsp);
    end
    checks++;
    if ({cmd_ready, pselx, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, paddr, pwdata, rsp_rdata} !== RESET_VEC) begin
      errors++;
      $display("FAIL rstmid_outputs: got %h required %h",
               {cmd_ready, pselx, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, paddr, pwdata, rsp_rdata}, RESET_VEC);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wait_read();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
